// File: rtl/fir_pkg.sv
// Shared defaults and FSM state type for the serial-FIR feed controller.
package fir_pkg;
  localparam int DW_DEF     = 12;
  localparam int YW_DEF     = 29;
  localparam int SLOT_DEF   = 8;
  localparam int FDEPTH_DEF = 4;
  localparam int TMO_DEF    = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } fsm_state_t;
endpackage

// File: rtl/fir_feed_ctrl_if.sv
// Upstream sample stream, serial-FIR handshake and downstream result stream.
// The master modport is the controller side; slave is the surrounding environment.
interface fir_feed_ctrl_if
  import fir_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int YW = YW_DEF
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          fir_en;
  logic [DW-1:0] fir_xin;
  logic          fir_rdy;
  logic [YW-1:0] fir_yout;
  logic          m_valid;
  logic          m_ready;
  logic [YW-1:0] m_data;
  logic          busy;
  logic          err;

  modport master (
    input  s_valid, s_data, fir_rdy, fir_yout, m_ready,
    output s_ready, fir_en, fir_xin, m_valid, m_data, busy, err
  );

  modport slave (
    output s_valid, s_data, fir_rdy, fir_yout, m_ready,
    input  s_ready, fir_en, fir_xin, m_valid, m_data, busy, err
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, no bypass: a push is visible at the head the following cycle.
// Pushes when full and pops when empty are ignored; pointers carry an extra wrap bit.
module sync_fifo #(
  parameter int DW     = 12,
  parameter int FDEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;

  logic [DW-1:0] mem_q [FDEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the head is only consumed when non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/fir_feed_ctrl.sv
// Feeds buffered samples to a serial FIR at most once per SLOT cycles and parks each result.
// Issue is withheld while the result register is occupied; a missing fir_rdy aborts after TMO cycles.
module fir_feed_ctrl
  import fir_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int YW     = YW_DEF,
  parameter int SLOT   = SLOT_DEF,
  parameter int FDEPTH = FDEPTH_DEF,
  parameter int TMO    = TMO_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  fir_feed_ctrl_if.master bus
);
  localparam int            GW      = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [GW-1:0] SLOT_M1 = GW'(SLOT - 1);
  localparam int            TW      = $clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_M1  = TW'(TMO - 1);

  fsm_state_t    state_q;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q;
  logic          fir_en_q;
  logic [DW-1:0] fir_xin_q;
  logic          m_valid_q;
  logic [YW-1:0] m_data_q;
  logic          err_q;

  logic          fifo_full, fifo_empty;
  logic [DW-1:0] fifo_head;
  logic          push, pop;
  logic          slot_free, issue_go, capture, timeout;

  assign push      = bus.s_valid && !fifo_full;
  assign pop       = (state_q == ST_ISSUE);
  assign slot_free = !m_valid_q || bus.m_ready;
  assign issue_go  = (state_q == ST_IDLE) && !fifo_empty && (gap_q >= SLOT_M1) && slot_free;
  assign capture   = (state_q == ST_WAIT) && bus.fir_rdy;
  assign timeout   = (state_q == ST_WAIT) && !bus.fir_rdy && (tmo_q == TMO_M1);
  assign gap_d     = (gap_q >= SLOT_M1) ? gap_q : gap_q + GW'(1);

  sync_fifo #(.DW(DW), .FDEPTH(FDEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.s_data),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gap_q     <= SLOT_M1;
      tmo_q     <= '0;
      fir_en_q  <= 1'b0;
      fir_xin_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      // Outputs are registered on the IDLE->ISSUE edge so they are valid throughout ISSUE.
      fir_en_q <= issue_go;
      gap_q    <= issue_go ? '0 : gap_d;
      if (issue_go) fir_xin_q <= fifo_head;

      case (state_q)
        ST_IDLE: begin
          if (issue_go) begin
            state_q <= ST_ISSUE;
            tmo_q   <= '0;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
          tmo_q   <= tmo_q + TW'(1);
        end
        ST_WAIT: begin
          tmo_q <= tmo_q + TW'(1);
          if (capture || timeout) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (capture) begin
        m_valid_q <= 1'b1;
        m_data_q  <= bus.fir_yout;
      end else if (bus.m_ready) begin
        m_valid_q <= 1'b0;
      end

      if (timeout) err_q <= 1'b1;
    end
  end

  assign bus.s_ready = !fifo_full;
  assign bus.fir_en  = fir_en_q;
  assign bus.fir_xin = fir_xin_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.busy    = (state_q != ST_IDLE) || !fifo_empty;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_fir_feed_ctrl.sv
// Directed bench for fir_feed_ctrl with a behavioural serial-FIR responder (rdy 3 cycles after en).
module tb_fir_feed_ctrl;
  localparam int DW = 12;
  localparam int YW = 29;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic          model_on = 1'b0;
  logic          model_rdy = 1'b0;
  logic [YW-1:0] model_yout = '0;
  logic          man_rdy = 1'b0;
  logic [YW-1:0] man_yout = '0;
  logic [DW-1:0] mx;

  fir_feed_ctrl_if #(.DW(DW), .YW(YW)) bus();

  fir_feed_ctrl #(.DW(DW), .YW(YW), .SLOT(8), .FDEPTH(4), .TMO(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.fir_rdy  = model_rdy | man_rdy;
  assign bus.fir_yout = man_rdy ? man_yout : model_yout;

  always #5 clk = ~clk;

  function automatic logic [YW-1:0] fir_ref(input logic [DW-1:0] x);
    logic [YW-1:0] v;
    v = YW'(x);
    return v * YW'(3) + YW'(1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FIR responder: result strobe in the third cycle after the cycle fir_en is seen.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (model_on && bus.fir_en === 1'b1) begin
        mx = bus.fir_xin;
        repeat (3) @(posedge clk);
        #1;
        model_rdy  = 1'b1;
        model_yout = fir_ref(mx);
        @(posedge clk);
        #1;
        model_rdy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic test_reset();
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready: got %b want 1", bus.s_ready); end
    n_cmp++; if (bus.fir_en !== 1'b0) begin n_bad++; $display("FAIL reset_fir_en: got %b want 0", bus.fir_en); end
    n_cmp++; if (bus.fir_xin !== 12'h000) begin n_bad++; $display("FAIL reset_fir_xin: got %h want 000", bus.fir_xin); end
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    n_cmp++; if (bus.m_data !== 29'h0) begin n_bad++; $display("FAIL reset_m_data: got %h want 0", bus.m_data); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.fir_en !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: fir_en=%b busy=%b want 0/0", bus.fir_en, bus.busy); end
  endtask

  task automatic test_single();
    int en_cnt, en_at, mv_at;
    logic [DW-1:0] xin;
    en_cnt = 0; en_at = -1; mv_at = -1; xin = '0;
    model_on = 1'b1;
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 12'h7FF;
    for (int c = 0; c < 20; c++) begin
      if (c == 1) bus.s_valid = 1'b0;
      if (bus.fir_en === 1'b1) begin
        en_cnt++;
        if (en_at < 0) begin en_at = c; xin = bus.fir_xin; end
      end
      if (bus.m_valid === 1'b1 && mv_at < 0) mv_at = c;
      tick();
    end
    n_cmp++; if (en_cnt != 1) begin n_bad++; $display("FAIL single_en_count: got %0d want 1", en_cnt); end
    n_cmp++; if (en_at != 2) begin n_bad++; $display("FAIL single_en_cycle: got %0d want 2", en_at); end
    n_cmp++; if (xin !== 12'h7FF) begin n_bad++; $display("FAIL single_fir_xin: got %h want 7ff", xin); end
    n_cmp++; if (mv_at != 6) begin n_bad++; $display("FAIL single_m_valid_cycle: got %0d want 6", mv_at); end
    n_cmp++; if (bus.m_data !== 29'h17FE) begin n_bad++; $display("FAIL single_m_data: got %h want 17fe", bus.m_data); end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    n_cmp++; if (bus.m_valid !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_drain: m_valid=%b busy=%b want 0/0", bus.m_valid, bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals [4];
    int en_c [$];
    logic [YW-1:0] res [$];
    vals[0] = 12'h101; vals[1] = 12'h202; vals[2] = 12'h303; vals[3] = 12'h404;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 45; c++) begin
      if (c < 4) begin
        n_cmp++; if (bus.s_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_s_ready[%0d]: got %b want 1", c, bus.s_ready); end
        bus.s_valid = 1'b1;
        bus.s_data  = vals[c];
      end else begin
        bus.s_valid = 1'b0;
      end
      if (bus.fir_en === 1'b1) en_c.push_back(c);
      if (bus.m_valid === 1'b1) res.push_back(bus.m_data);
      tick();
    end
    bus.m_ready = 1'b0;
    n_cmp++; if (en_c.size() != 4) begin n_bad++; $display("FAIL b2b_en_count: got %0d want 4", en_c.size()); end
    n_cmp++; if (en_c.size() < 1 || en_c[0] != 2) begin n_bad++; $display("FAIL b2b_first_en: got %0d want 2", (en_c.size() > 0) ? en_c[0] : -1); end
    for (int i = 1; i < en_c.size(); i++) begin
      n_cmp++; if (en_c[i] - en_c[i-1] != 8) begin n_bad++; $display("FAIL b2b_en_gap[%0d]: got %0d want 8", i, en_c[i] - en_c[i-1]); end
    end
    n_cmp++; if (res.size() != 4) begin n_bad++; $display("FAIL b2b_result_count: got %0d want 4", res.size()); end
    for (int i = 0; i < res.size() && i < 4; i++) begin
      n_cmp++; if (res[i] !== fir_ref(vals[i])) begin n_bad++; $display("FAIL b2b_result[%0d]: got %h want %h", i, res[i], fir_ref(vals[i])); end
    end
  endtask

  task automatic test_backpressure();
    int en_c [$];
    logic [DW-1:0] xs [$];
    bus.m_ready = 1'b0;
    for (int c = 0; c < 36; c++) begin
      bus.s_valid = (c < 2);
      if (c == 0) bus.s_data = 12'h0A5;
      else        bus.s_data = 12'h15A;
      bus.m_ready = (c == 25);
      if (c == 25) begin
        n_cmp++; if (bus.m_valid !== 1'b1 || bus.m_data !== fir_ref(12'h0A5)) begin n_bad++; $display("FAIL bp_held_result: m_valid=%b m_data=%h want 1/%h", bus.m_valid, bus.m_data, fir_ref(12'h0A5)); end
      end
      if (bus.fir_en === 1'b1) begin en_c.push_back(c); xs.push_back(bus.fir_xin); end
      tick();
    end
    n_cmp++; if (en_c.size() != 2) begin n_bad++; $display("FAIL bp_en_count: got %0d want 2", en_c.size()); end
    n_cmp++; if (en_c.size() < 2 || en_c[1] != 26) begin n_bad++; $display("FAIL bp_second_en_cycle: got %0d want 26", (en_c.size() > 1) ? en_c[1] : -1); end
    n_cmp++; if (xs.size() < 2 || xs[1] !== 12'h15A) begin n_bad++; $display("FAIL bp_second_xin: got %h want 15a", (xs.size() > 1) ? xs[1] : 12'h000); end
    n_cmp++; if (bus.m_valid !== 1'b1 || bus.m_data !== fir_ref(12'h15A)) begin n_bad++; $display("FAIL bp_second_result: m_valid=%b m_data=%h want 1/%h", bus.m_valid, bus.m_data, fir_ref(12'h15A)); end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
  endtask

  task automatic test_capture_with_ready();
    bus.m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.s_valid = (c == 0);
      bus.s_data  = 12'h3C3;
      if (c == 5) begin
        n_cmp++; if (bus.m_valid !== 1'b0 || bus.m_data !== fir_ref(12'h15A)) begin n_bad++; $display("FAIL cap_before: m_valid=%b m_data=%h want 0/%h", bus.m_valid, bus.m_data, fir_ref(12'h15A)); end
      end
      if (c == 6) begin
        n_cmp++; if (bus.m_valid !== 1'b1 || bus.m_data !== fir_ref(12'h3C3)) begin n_bad++; $display("FAIL cap_same_cycle_ready: m_valid=%b m_data=%h want 1/%h", bus.m_valid, bus.m_data, fir_ref(12'h3C3)); end
      end
      if (c == 7) begin
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL cap_consumed: m_valid=%b want 0", bus.m_valid); end
      end
      tick();
    end
    bus.m_ready = 1'b0;
  endtask

  task automatic test_full_timeout();
    logic [DW-1:0] s [5];
    logic [DW-1:0] xs [$];
    int en_cnt;
    s[0] = 12'h100; s[1] = 12'h200; s[2] = 12'h300; s[3] = 12'h400; s[4] = 12'h500;
    en_cnt = 0;
    // Park one result so nothing can issue while the FIFO fills.
    bus.m_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.s_valid = (c == 0);
      bus.s_data  = 12'h011;
      tick();
    end
    n_cmp++; if (bus.m_valid !== 1'b1) begin n_bad++; $display("FAIL full_parked: m_valid=%b want 1", bus.m_valid); end
    model_on = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c < 5) begin
        n_cmp++; if (bus.s_ready !== (c < 4)) begin n_bad++; $display("FAIL full_s_ready[%0d]: got %b want %b", c, bus.s_ready, (c < 4)); end
        bus.s_valid = 1'b1;
        bus.s_data  = s[c];
      end else begin
        bus.s_valid = 1'b0;
      end
      if (bus.fir_en === 1'b1) en_cnt++;
      tick();
    end
    n_cmp++; if (en_cnt != 0) begin n_bad++; $display("FAIL full_no_issue: got %0d fir_en want 0", en_cnt); end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    n_cmp++; if (bus.fir_en !== 1'b1 || bus.fir_xin !== 12'h100) begin n_bad++; $display("FAIL tmo_issue: fir_en=%b xin=%h want 1/100", bus.fir_en, bus.fir_xin); end
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 63) begin
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL tmo_err_early: got %b want 0 at 63", bus.err); end
        model_on = 1'b1;
      end
      if (k == 64) begin
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL tmo_err: got %b want 1 at 64", bus.err); end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_m_valid: got %b want 0", bus.m_valid); end
      end
    end
    bus.m_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus.fir_en === 1'b1) xs.push_back(bus.fir_xin);
      tick();
    end
    bus.m_ready = 1'b0;
    n_cmp++; if (xs.size() != 3) begin n_bad++; $display("FAIL tmo_retained_count: got %0d want 3", xs.size()); end
    for (int i = 0; i < xs.size() && i < 3; i++) begin
      n_cmp++; if (xs[i] !== s[i+1]) begin n_bad++; $display("FAIL tmo_retained[%0d]: got %h want %h", i, xs[i], s[i+1]); end
    end
    n_cmp++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL tmo_sticky: err=%b busy=%b want 1/0", bus.err, bus.busy); end
  endtask

  task automatic test_reset_mid_wait();
    int en_cnt;
    en_cnt = 0;
    model_on = 1'b0;
    bus.m_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.s_valid = (c == 0);
      bus.s_data  = 12'h2AA;
      if (bus.fir_en === 1'b1) en_cnt++;
      tick();
    end
    n_cmp++; if (en_cnt != 1 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL rst_wait_setup: en=%0d busy=%b want 1/1", en_cnt, bus.busy); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    man_rdy  = 1'b1;
    man_yout = 29'h1234567;
    tick();
    man_rdy = 1'b0;
    en_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.fir_en === 1'b1) en_cnt++;
      tick();
    end
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wait_m_valid: got %b want 0", bus.m_valid); end
    n_cmp++; if (bus.m_data !== 29'h0) begin n_bad++; $display("FAIL rst_wait_m_data: got %h want 0", bus.m_data); end
    n_cmp++; if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_wait_fifo_empty: s_ready=%b busy=%b want 1/0", bus.s_ready, bus.busy); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL rst_wait_err: got %b want 0", bus.err); end
    n_cmp++; if (en_cnt != 0) begin n_bad++; $display("FAIL rst_wait_no_issue: got %0d fir_en want 0", en_cnt); end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_capture_with_ready();
    test_full_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fir_feed_ctrl.md
FIR_FEED_CTRL -- requirements
Module: fir_feed_ctrl

Interface
REQ-001 SHALL have parameter DW, default 12, sample width.
REQ-002 SHALL have parameter YW, default 29, filter result width.
REQ-003 SHALL have parameter SLOT, default 8, minimum clk cycles between fir_en pulses.
REQ-004 SHALL have parameter FDEPTH, default 4, input FIFO depth (power of 2).
REQ-005 SHALL have parameter TMO, default 64, cycles to wait for fir_rdy before abort.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 s_valid  input  1  upstream sample valid.
REQ-009 s_ready  output  1  FIFO can accept; equals !fifo_full.
REQ-010 s_data  input  DW  upstream sample.
REQ-011 fir_en  output  1  one-cycle start pulse to the serial FIR.
REQ-012 fir_xin  output  DW  sample to the FIR; held from issue until the next issue.
REQ-013 fir_rdy  input  1  FIR result strobe.
REQ-014 fir_yout  input  YW  FIR result, sampled when fir_rdy=1.
REQ-015 m_valid  output  1  result register full.
REQ-016 m_ready  input  1  downstream accepts.
REQ-017 m_data  output  YW  captured result.
REQ-018 busy  output  1  FSM not in IDLE, or FIFO non-empty.
REQ-019 err  output  1  sticky timeout flag.

Function
REQ-020 SHALL push s_data on s_valid&&s_ready; FIFO full rejects (s_ready=0), no overwrite.
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-022 IDLE->ISSUE SHALL occur when the FIFO is non-empty, gap counter >= SLOT-1, and the result slot is free (!m_valid, or m_valid&&m_ready this cycle).
REQ-023 ISSUE SHALL last exactly one cycle: fir_en=1, FIFO popped, fir_xin loaded with the head entry, gap counter cleared to 0; then go to WAIT.
REQ-024 Gap counter SHALL increment every cycle after ISSUE, saturating at SLOT-1; back-to-back fir_en pulses are therefore exactly SLOT cycles apart at full throughput.
REQ-025 WAIT SHALL capture fir_yout into m_data and set m_valid on the cycle fir_rdy=1, then return to IDLE.
REQ-026 WAIT SHALL count cycles; on reaching TMO without fir_rdy it SHALL set err=1, leave m_valid unchanged, and return to IDLE.
REQ-027 fir_rdy outside WAIT SHALL be ignored.
REQ-028 m_valid SHALL clear on m_valid&&m_ready unless a capture occurs in the same cycle, in which case it stays 1 with the new data.
REQ-029 Simultaneous FIFO push and pop SHALL leave the count unchanged; a push to an empty FIFO is not issuable until the next cycle (no bypass).
REQ-030 FIFO pointers SHALL wrap modulo FDEPTH using an extra MSB for full/empty detection.
REQ-031 err SHALL remain 1 until reset; operation continues after timeout.

Reset
REQ-032 On rst_n=0, the block SHALL asynchronously enter IDLE and set fir_en=0, fir_xin=0, m_valid=0, m_data=0, err=0, FIFO empty (s_ready=1), and gap counter=SLOT-1 (first issue is allowed immediately).
REQ-033 Reset mid-WAIT SHALL discard the in-flight result; a fir_rdy arriving after release SHALL be ignored.

Structure
REQ-034 A shared package fir_pkg SHALL hold DW/YW defaults, the FSM state enum type, and SLOT/TMO defaults.
REQ-035 The input FIFO SHALL be a sub-module sync_fifo (DW, FDEPTH); FSM, counters and result register are in fir_feed_ctrl.

Verification
REQ-036 Reset then push 0x7FF with FIR model rdy 3 cycles after en: fir_en pulses once with fir_xin=0x7FF, and m_valid rises 4 cycles after fir_en.
REQ-037 Push 4 samples back-to-back with m_ready=1: s_ready stays 1 for 4 pushes, fir_en pulses exactly 8 cycles apart, and 4 results come out in order.
REQ-038 Push 5 samples with no pops possible (FIR model never asserts rdy): the 5th push sees s_ready=0, err=1 at 64 cycles after the first fir_en, and the FIFO retains entries 2-4.
REQ-039 Hold m_ready=0 after the first result: the second fir_en is withheld until m_ready pulses, then it issues on the next eligible cycle.
REQ-040 Assert rst_n=0 for 1 cycle during WAIT, then deliver a stale fir_rdy: m_valid stays 0, FIFO is empty, and err=0.
REQ-041 Capture and m_ready occur in the same cycle: m_valid stays 1 and m_data updates to the new value.
